// File: rtl/serial_magnitude_comparator_if.sv
// Request/result bundle between a comparison requester and serial_magnitude_comparator.
interface serial_magnitude_comparator_if #(
   parameter int unsigned WIDTH = 20
);
   logic             start;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             sgn;
   logic             busy;
   logic             valid;
   logic             Lt;
   logic             Gt;
   logic             Eq;

   modport master (
      output start, A, B, sgn,
      input  busy, valid, Lt, Gt, Eq
   );

   modport slave (
      input  start, A, B, sgn,
      output busy, valid, Lt, Gt, Eq
   );
endinterface

// File: rtl/serial_magnitude_comparator.sv
// Digit-serial magnitude comparator: one DIGIT-wide slice per cycle, MSB slice first.
// Optional build macro SERIAL_CMP_EARLY_EXIT_EN finishes on the first differing slice.
module serial_magnitude_comparator #(
   parameter int unsigned WIDTH = 20,
   parameter int unsigned DIGIT = 4
) (
   input logic                          clk,
   input logic                          rst_n,
   serial_magnitude_comparator_if.slave bus
);
   localparam int unsigned NDIG = WIDTH / DIGIT;
   localparam int unsigned IW   = (NDIG > 1) ? $clog2(NDIG) : 1;

   generate
      if ((WIDTH % DIGIT) != 0) begin : g_bad_cfg
         $error("serial_magnitude_comparator: WIDTH must be a multiple of DIGIT");
      end
   endgenerate

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_CMP  = 1'b1
   } state_t;

   state_t           r_state, w_state;
   logic [IW-1:0]    r_idx, w_idx;
   logic [WIDTH-1:0] r_a, w_a;
   logic [WIDTH-1:0] r_b, w_b;
   logic             r_sgn, w_sgn;
   logic             r_lt, w_lt;
   logic             r_gt, w_gt;
   logic             r_eq, w_eq;
   logic             r_busy, w_busy;
   logic             r_valid, w_valid;
   logic             r_o_lt, w_o_lt;
   logic             r_o_gt, w_o_gt;
   logic             r_o_eq, w_o_eq;

   logic [DIGIT-1:0] w_sa, w_sb;
   logic             w_dlt, w_dgt, w_deq;
   logic             w_last, w_done;

   // Current slice, with the sign bit flipped on the top slice for signed compares
   always_comb begin
      w_sa = DIGIT'(r_a >> (32'(r_idx) * DIGIT));
      w_sb = DIGIT'(r_b >> (32'(r_idx) * DIGIT));
      if (r_sgn && (r_idx == IW'(NDIG - 1))) begin
         w_sa[DIGIT-1] = ~w_sa[DIGIT-1];
         w_sb[DIGIT-1] = ~w_sb[DIGIT-1];
      end
   end

   // Accumulator: only the first differing slice decides the result
   always_comb begin
      w_dlt = r_lt;
      w_dgt = r_gt;
      w_deq = r_eq;
      if (r_eq && (w_sa != w_sb)) begin
         w_dlt = (w_sa < w_sb);
         w_dgt = (w_sa > w_sb);
         w_deq = 1'b0;
      end
   end

   assign w_last = (r_idx == '0);
`ifdef SERIAL_CMP_EARLY_EXIT_EN
   assign w_done = w_last || !w_deq;
`else
   assign w_done = w_last;
`endif

   // Next-state and registered-output logic
   always_comb begin
      w_state = r_state;
      w_idx   = r_idx;
      w_a     = r_a;
      w_b     = r_b;
      w_sgn   = r_sgn;
      w_lt    = r_lt;
      w_gt    = r_gt;
      w_eq    = r_eq;
      w_busy  = r_busy;
      w_valid = 1'b0;
      w_o_lt  = r_o_lt;
      w_o_gt  = r_o_gt;
      w_o_eq  = r_o_eq;
      case (r_state)
         ST_IDLE: begin
            if (bus.start) begin
               w_state = ST_CMP;
               w_idx   = IW'(NDIG - 1);
               w_a     = bus.A;
               w_b     = bus.B;
               w_sgn   = bus.sgn;
               w_lt    = 1'b0;
               w_gt    = 1'b0;
               w_eq    = 1'b1;
               w_busy  = 1'b1;
            end
         end
         ST_CMP: begin
            w_lt = w_dlt;
            w_gt = w_dgt;
            w_eq = w_deq;
            if (w_done) begin
               w_state = ST_IDLE;
               w_busy  = 1'b0;
               w_valid = 1'b1;
               w_o_lt  = w_dlt;
               w_o_gt  = w_dgt;
               w_o_eq  = w_deq;
            end else begin
               w_idx = r_idx - IW'(1);
            end
         end
         default: begin
            w_state = ST_IDLE;
            w_busy  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_idx   <= '0;
         r_a     <= '0;
         r_b     <= '0;
         r_sgn   <= 1'b0;
         r_lt    <= 1'b0;
         r_gt    <= 1'b0;
         r_eq    <= 1'b0;
         r_busy  <= 1'b0;
         r_valid <= 1'b0;
         r_o_lt  <= 1'b0;
         r_o_gt  <= 1'b0;
         r_o_eq  <= 1'b0;
      end else begin
         r_state <= w_state;
         r_idx   <= w_idx;
         r_a     <= w_a;
         r_b     <= w_b;
         r_sgn   <= w_sgn;
         r_lt    <= w_lt;
         r_gt    <= w_gt;
         r_eq    <= w_eq;
         r_busy  <= w_busy;
         r_valid <= w_valid;
         r_o_lt  <= w_o_lt;
         r_o_gt  <= w_o_gt;
         r_o_eq  <= w_o_eq;
      end
   end

   assign bus.busy  = r_busy;
   assign bus.valid = r_valid;
   assign bus.Lt    = r_o_lt;
   assign bus.Gt    = r_o_gt;
   assign bus.Eq    = r_o_eq;
endmodule
